zero_heap_allocator: RTL
========================

Name: zero_heap_allocator

Overview:
- Hardware heap for the zero VM: allocates, frees, reads and writes fixed-area arrays, and tracks each array's current length.
- Generalises the inline array/free-stack/heap logic of the generated program modules into one reusable, parameterised block behind a request/response handshake.
- Sits between the VM instruction sequencer and heap storage; one request is in flight at a time.

Parameters:
- WIDTH, 12, heap element and data width in bits.
- NARRAYS, 64, maximum number of simultaneously allocatable arrays.
- NAREA, 10, elements per array area.
- AW, $clog2(NARRAYS), array handle width (derived).
- IW, $clog2(NAREA+1), index and size width (derived).

Ports:
- clock  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_op  in  3  0=ALLOC 1=FREE 2=WRITE 3=READ 4=SIZE 5=RESIZE; 6 and 7 are reserved.
- req_array  in  AW  target array handle (ignored for ALLOC).
- req_index  in  IW  element index, or new size for RESIZE.
- req_data  in  WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_data  out  WIDTH  handle (ALLOC), element (READ), size (SIZE/RESIZE), otherwise 0.
- rsp_error  out  1  request rejected; no state changed.
- live_count  out  AW+1  arrays currently allocated.
- high_water  out  AW+1  number of arrays ever handed out (bump pointer).

Behaviour:
- Reset (async, any time, including mid-operation): state=INIT, req_ready=0, rsp_valid=0, rsp_data=0, rsp_error=0, live_count=0, high_water=0, free-stack top=0, all live bits=0, clear counter=0.
- INIT: writes 0 to one heap word per cycle and clears sizes. Runs NARRAYS*NAREA cycles, then enters IDLE. req_ready is first high on cycle NARRAYS*NAREA after reset deassertion.
- IDLE: req_ready=1. Acceptance is req_valid&&req_ready. Request fields are captured and the block moves to EXEC. req_ready is 0 in every other state.
- EXEC: performs the operation in one cycle, loads the response registers, then moves to RESP.
- RESP: rsp_valid=1 and the response registers are held stable until rsp_ready=1, then the block returns to IDLE. Accept-to-rsp_valid latency is 2 cycles. rsp_ready high with rsp_valid low has no effect.
- ALLOC:
  - If the free stack is non-empty, pop it (LIFO) and return the popped handle.
  - Otherwise, if high_water<NARRAYS, return high_water and increment it.
  - Otherwise set rsp_error.
  - On success: size[h]=0, live[h]=1, live_count+1. Heap contents are not cleared.
- FREE: error if live[a]=0 (double free or never allocated). Otherwise push a onto the stack, live[a]=0, live_count-1. The stack never exceeds NARRAYS entries because only live handles are pushed.
- WRITE: error if !live[a] or index>=NAREA. Otherwise heap[a*NAREA+index]=data and size[a]=max(size[a], index+1).
- READ: same error checks as WRITE. Returns heap[a*NAREA+index], including when index>=size[a] (stale data is permitted).
- SIZE: error if !live[a]. Returns size[a].
- RESIZE: error if !live[a] or index>NAREA. Otherwise size[a]=index; returns the new size.
- Reserved op codes (6, 7): rsp_error=1, rsp_data=0.
- Arithmetic: heap address a*NAREA+index is computed in $clog2(NARRAYS*NAREA) bits. Sizes saturate at NAREA by construction.
- Heap: single-port RAM with synchronous write and combinational read. INIT and EXEC never access it in the same cycle.

Decomposition:
- zero_heap_pkg holds:
  - op enum (ALLOC..RESIZE);
  - state enum (INIT, IDLE, EXEC, RESP);
  - localparams for the heap depth function.
- Sub-module zero_free_stack: a LIFO of NARRAYS x AW with push, pop, empty, full and top.
- The heap RAM and size/live arrays stay in the top module.

Test Plan:
- Reset release -> req_ready stays 0 for exactly 640 cycles (64*10), then 1. Reads of arrays 0..63 after ALLOC return 0.
- ALLOC, then WRITE idx0=1, idx1=2, idx2=3 -> handle 0, SIZE=3, READ idx1=2, rsp_valid exactly 2 cycles after each accept.
- ALLOC x3 (handles 0,1,2), FREE 1, FREE 0, ALLOC x2 -> handles 0 then 1 (LIFO). high_water=3, live_count=3.
- ALLOC 65 times -> first 64 succeed, 65th rsp_error=1. FREE 5 twice -> second rsp_error=1. WRITE index 10 -> rsp_error, SIZE unchanged.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_error stable and req_ready=0 throughout. Assert reset mid-RESP -> all outputs return to reset values asynchronously and INIT reruns.
- RESIZE array to 2 after size 3, then WRITE idx0 -> SIZE=2. RESIZE 11 -> error. Ops 6 and 7 -> error.

Source files
------------

// File: rtl/zero_heap_pkg.sv
// Shared types and sizing helpers for the zero VM hardware heap.
package zero_heap_pkg;

   typedef enum logic [2:0] {
      OP_ALLOC  = 3'd0,
      OP_FREE   = 3'd1,
      OP_WRITE  = 3'd2,
      OP_READ   = 3'd3,
      OP_SIZE   = 3'd4,
      OP_RESIZE = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_e;

   localparam int DEFAULT_NARRAYS = 64;
   localparam int DEFAULT_NAREA   = 10;

   function automatic int heap_depth(input int narrays, input int narea);
      return narrays * narea;
   endfunction

   // Address width for the flat heap; never narrower than one bit.
   function automatic int heap_aw(input int narrays, input int narea);
      return (narrays * narea > 1) ? $clog2(narrays * narea) : 1;
   endfunction

endpackage

// File: rtl/zero_free_stack.sv
// LIFO of released array handles; top shows the most recently pushed entry.
module zero_free_stack #(
   parameter int NARRAYS = 64,
   parameter int AW      = $clog2(NARRAYS)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_data,
   output logic          empty,
   output logic          full,
   output logic [AW-1:0] top
);

   logic [AW-1:0] stack_mem [NARRAYS];
   logic [AW:0]   sp_reg;
   logic [AW-1:0] top_idx;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sp_reg <= '0;
      end else if (push && !full) begin
         sp_reg <= sp_reg + (AW+1)'(1);
      end else if (pop && !empty) begin
         sp_reg <= sp_reg - (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push && !full) begin
         stack_mem[sp_reg[AW-1:0]] <= push_data;
      end
   end

   // Low bits of sp minus one wrap correctly even when the stack is full.
   assign top_idx = sp_reg[AW-1:0] - AW'(1);
   assign top     = stack_mem[top_idx];
   assign empty   = (sp_reg == '0);
   assign full    = (sp_reg == (AW+1)'(NARRAYS));

endmodule

// File: rtl/zero_heap_allocator.sv
// Hardware heap for the zero VM: alloc/free/read/write/size/resize of fixed-area
// arrays behind a single-outstanding request/response handshake.
module zero_heap_allocator
   import zero_heap_pkg::*;
#(
   parameter int WIDTH   = 12,
   parameter int NARRAYS = DEFAULT_NARRAYS,
   parameter int NAREA   = DEFAULT_NAREA,
   parameter int AW      = $clog2(NARRAYS),
   parameter int IW      = $clog2(NAREA + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [AW-1:0]    req_array,
   input  logic [IW-1:0]    req_index,
   input  logic [WIDTH-1:0] req_data,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_error,
   output logic [AW:0]      live_count,
   output logic [AW:0]      high_water
);

   localparam int DEPTH = heap_depth(NARRAYS, NAREA);
   localparam int HAW   = heap_aw(NARRAYS, NAREA);

   state_e state_reg, state_next;

   logic [HAW-1:0]   clear_cnt_reg;
   logic [2:0]       op_reg;
   logic [AW-1:0]    array_reg;
   logic [IW-1:0]    index_reg;
   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
   logic             rsp_error_reg, rsp_error_next;
   logic [AW:0]      live_count_reg, high_water_reg;
   logic [NARRAYS-1:0] live_reg;

   logic [IW-1:0]    size_mem [NARRAYS];
   logic [WIDTH-1:0] heap_mem [DEPTH];

   logic             heap_we;
   logic [HAW-1:0]   heap_addr, exec_addr;
   logic [WIDTH-1:0] heap_wdata, heap_rdata;
   logic             size_we;
   logic [AW-1:0]    size_waddr;
   logic [IW-1:0]    size_wdata, cur_size, idx_plus1;
   logic             live_set, live_clr, live_a, index_ok;
   logic [AW-1:0]    live_idx;
   logic             hw_inc, lc_inc, lc_dec;
   logic             stack_push, stack_pop, stack_empty, stack_full;
   logic [AW-1:0]    stack_top;

   zero_free_stack #(.NARRAYS(NARRAYS), .AW(AW)) u_free_stack (
      .clock     (clock),
      .reset     (reset),
      .push      (stack_push),
      .pop       (stack_pop),
      .push_data (array_reg),
      .empty     (stack_empty),
      .full      (stack_full),
      .top       (stack_top)
   );

   assign exec_addr  = HAW'(array_reg) * HAW'(NAREA) + HAW'(index_reg);
   assign heap_rdata = heap_mem[heap_addr];
   assign cur_size   = size_mem[array_reg];
   assign idx_plus1  = index_reg + IW'(1);
   assign live_a     = live_reg[array_reg];
   assign index_ok   = (index_reg < IW'(NAREA));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= ST_INIT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      heap_we        = 1'b0;
      heap_addr      = exec_addr;
      heap_wdata     = data_reg;
      size_we        = 1'b0;
      size_waddr     = array_reg;
      size_wdata     = '0;
      live_set       = 1'b0;
      live_clr       = 1'b0;
      live_idx       = array_reg;
      hw_inc         = 1'b0;
      lc_inc         = 1'b0;
      lc_dec         = 1'b0;
      stack_push     = 1'b0;
      stack_pop      = 1'b0;
      rsp_data_next  = rsp_data_reg;
      rsp_error_next = rsp_error_reg;
      case (state_reg)
         ST_INIT: begin
            heap_we    = 1'b1;
            heap_addr  = clear_cnt_reg;
            heap_wdata = '0;
            size_waddr = clear_cnt_reg[AW-1:0];
            size_we    = (int'(clear_cnt_reg) < NARRAYS);
            if (clear_cnt_reg == HAW'(DEPTH - 1)) begin
               state_next = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (req_valid) begin
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_next     = ST_RESP;
            rsp_data_next  = '0;
            rsp_error_next = 1'b0;
            case (op_e'(op_reg))
               OP_ALLOC: begin
                  // Recycled handles take priority over bumping high_water.
                  if (!stack_empty) begin
                     stack_pop = 1'b1;
                     live_idx  = stack_top;
                  end else if (high_water_reg < (AW+1)'(NARRAYS)) begin
                     hw_inc   = 1'b1;
                     live_idx = high_water_reg[AW-1:0];
                  end else begin
                     rsp_error_next = 1'b1;
                  end
                  if (!rsp_error_next) begin
                     live_set      = 1'b1;
                     lc_inc        = 1'b1;
                     size_we       = 1'b1;
                     size_waddr    = live_idx;
                     rsp_data_next = WIDTH'(live_idx);
                  end
               end
               OP_FREE: begin
                  if (!live_a) begin
                     rsp_error_next = 1'b1;
                  end else begin
                     stack_push = !stack_full;
                     live_clr   = 1'b1;
                     lc_dec     = 1'b1;
                  end
               end
               OP_WRITE: begin
                  if (!live_a || !index_ok) begin
                     rsp_error_next = 1'b1;
                  end else begin
                     heap_we = 1'b1;
                     if (index_reg >= cur_size) begin
                        size_we    = 1'b1;
                        size_wdata = idx_plus1;
                     end
                  end
               end
               OP_READ: begin
                  if (!live_a || !index_ok) begin
                     rsp_error_next = 1'b1;
                  end else begin
                     rsp_data_next = heap_rdata;
                  end
               end
               OP_SIZE: begin
                  if (!live_a) begin
                     rsp_error_next = 1'b1;
                  end else begin
                     rsp_data_next = WIDTH'(cur_size);
                  end
               end
               OP_RESIZE: begin
                  if (!live_a || index_reg > IW'(NAREA)) begin
                     rsp_error_next = 1'b1;
                  end else begin
                     size_we       = 1'b1;
                     size_wdata    = index_reg;
                     rsp_data_next = WIDTH'(index_reg);
                  end
               end
               default: rsp_error_next = 1'b1;
            endcase
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clear_cnt_reg  <= '0;
         op_reg         <= '0;
         array_reg      <= '0;
         index_reg      <= '0;
         data_reg       <= '0;
         rsp_data_reg   <= '0;
         rsp_error_reg  <= 1'b0;
         live_count_reg <= '0;
         high_water_reg <= '0;
         live_reg       <= '0;
      end else begin
         if (state_reg == ST_INIT) begin
            clear_cnt_reg <= clear_cnt_reg + HAW'(1);
         end
         if (state_reg == ST_IDLE && req_valid) begin
            op_reg    <= req_op;
            array_reg <= req_array;
            index_reg <= req_index;
            data_reg  <= req_data;
         end
         rsp_data_reg  <= rsp_data_next;
         rsp_error_reg <= rsp_error_next;
         if (hw_inc) begin
            high_water_reg <= high_water_reg + (AW+1)'(1);
         end
         if (lc_inc) begin
            live_count_reg <= live_count_reg + (AW+1)'(1);
         end else if (lc_dec) begin
            live_count_reg <= live_count_reg - (AW+1)'(1);
         end
         if (live_set) begin
            live_reg[live_idx] <= 1'b1;
         end else if (live_clr) begin
            live_reg[live_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (heap_we) begin
         heap_mem[heap_addr] <= heap_wdata;
      end
      if (size_we) begin
         size_mem[size_waddr] <= size_wdata;
      end
   end

   assign req_ready  = (state_reg == ST_IDLE);
   assign rsp_valid  = (state_reg == ST_RESP);
   assign rsp_data   = rsp_data_reg;
   assign rsp_error  = rsp_error_reg;
   assign live_count = live_count_reg;
   assign high_water = high_water_reg;

endmodule
